// File: rtl/updn_counter_ld.sv
// updn_counter_ld: parametrised up/down counter with synchronous load,
// programmable terminal value, wrap/saturate boundary handling and a
// clock-enable prescaler. Emits a one-cycle terminal-count pulse (tc) and a
// sticky overflow flag (ovf) on every boundary event.
module updn_counter_ld #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   din,
  input  logic               en,
  input  logic               up,
  input  logic               sat,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr_ovf,
  output logic [WIDTH-1:0]   cnt,
  output logic               tc,
  output logic               ovf,
  output logic               zero
);

  logic [WIDTH-1:0]   r_cnt;
  logic [PRESC_W-1:0] r_pc;
  logic               r_tc;
  logic               r_ovf;

  logic               w_tick;
  logic               w_at_top;
  logic               w_at_bottom;
  logic               w_event;
  logic [WIDTH-1:0]   w_cnt_next;

  // A tick happens on the enabled cycle where the prescaler reaches presc;
  // load suppresses it because load has priority over counting.
  assign w_tick      = en && !load && (r_pc == presc);

  // ">=" rather than "==" so a loaded value above max_val still hits the
  // boundary on the next up tick instead of running on to 2^WIDTH.
  assign w_at_top    = (r_cnt >= max_val);
  assign w_at_bottom = (r_cnt == '0);
  assign w_event     = w_tick && (up ? w_at_top : w_at_bottom);

  // Next count value for a tick, including the wrap/saturate boundary cases.
  always_comb begin
    w_cnt_next = r_cnt;
    if (up) begin
      if (w_at_top) w_cnt_next = sat ? max_val : '0;
      else          w_cnt_next = r_cnt + 1'b1;
    end else begin
      if (w_at_bottom) w_cnt_next = sat ? '0 : max_val;
      else             w_cnt_next = r_cnt - 1'b1;
    end
  end

  // Prescaler: restarts on load, advances only on enabled cycles, and wraps
  // to zero on the tick cycle; it freezes while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= '0;
    end else if (en) begin
      if (r_pc == presc) r_pc <= '0;
      else               r_pc <= r_pc + 1'b1;
    end
  end

  // Counter and terminal-count pulse: load beats tick, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_cnt <= din;
      r_tc  <= 1'b0;
    end else begin
      if (w_tick) r_cnt <= w_cnt_next;
      r_tc <= w_event;
    end
  end

  // Sticky overflow: a boundary event on the same edge overrides a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_event) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign zero = (r_cnt == '0);

endmodule

// File: tb/tb_updn_counter_ld.sv
// Self-checking bench for updn_counter_ld: directed scenarios followed by
// randomized traffic, all compared against an integer reference model.
module tb_updn_counter_ld;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  logic               clk;
  logic               rst;
  logic               load;
  logic [WIDTH-1:0]   din;
  logic               en;
  logic               up;
  logic               sat;
  logic [WIDTH-1:0]   max_val;
  logic [PRESC_W-1:0] presc;
  logic               clr_ovf;
  logic [WIDTH-1:0]   cnt;
  logic               tc;
  logic               ovf;
  logic               zero;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers)
  int m_cnt, m_pc, m_tc, m_ovf;

  updn_counter_ld #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en), .up(up),
    .sat(sat), .max_val(max_val), .presc(presc), .clr_ovf(clr_ovf),
    .cnt(cnt), .tc(tc), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_tc = 0; m_ovf = 0;
  endtask

  // One clock edge of the specified behaviour, using the current inputs.
  task automatic model_edge();
    int lim, ev, tick;
    lim = int'(max_val);
    if (load) begin
      m_cnt = int'(din);
      m_pc  = 0;
      m_tc  = 0;
      if (clr_ovf) m_ovf = 0;
    end else begin
      tick = 0;
      ev   = 0;
      if (en) begin
        if (m_pc == int'(presc)) begin
          tick = 1;
          m_pc = 0;
        end else begin
          m_pc = (m_pc + 1) % (1 << PRESC_W);
        end
      end
      if (tick) begin
        if (up) begin
          if (m_cnt < lim) m_cnt = m_cnt + 1;
          else begin ev = 1; m_cnt = sat ? lim : 0; end
        end else begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else begin ev = 1; m_cnt = sat ? 0 : lim; end
        end
      end
      m_tc = ev;
      if (ev) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    check({tag, ".tc"},   32'(tc),   32'(m_tc));
    check({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
    check({tag, ".zero"}, 32'(zero), 32'(m_cnt == 0));
  endtask

  // Advance one clock edge, update the model, sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    din  = v;
    step("load");
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = '0; en = 1'b0; up = 1'b1; sat = 1'b0;
    max_val = 8'd255; presc = '0; clr_ovf = 1'b0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic up count with wrap at 255
    en = 1'b1;
    repeat (256) step("upcount");
    check("wrap_cnt", 32'(cnt), 32'd0);
    check("wrap_tc",  32'(tc),  32'd1);
    check("wrap_ovf", 32'(ovf), 32'd1);
    step("after_wrap");
    check("tc_one_cycle", 32'(tc), 32'd0);

    // Load beats tick
    repeat (4) step("to5");
    check("at5", 32'(cnt), 32'd5);
    do_load(8'hA0);
    check("load_pri", 32'(cnt), 32'hA0);
    step("after_load");
    check("load_cont", 32'(cnt), 32'hA1);

    // Down count, wrap then saturate
    max_val = 8'd9; up = 1'b0; sat = 1'b0;
    do_load(8'd2);
    step("dn"); step("dn"); step("dn");
    check("dn_wrap_cnt", 32'(cnt), 32'd9);
    check("dn_wrap_tc",  32'(tc),  32'd1);
    step("dn");
    check("dn_after", 32'(cnt), 32'd8);
    sat = 1'b1;
    do_load(8'd2);
    repeat (4) step("dn_sat");
    check("dn_sat_cnt", 32'(cnt), 32'd0);
    check("dn_sat_tc",  32'(tc),  32'd1);

    // Prescaler with an enable gap
    up = 1'b1; sat = 1'b0; max_val = 8'd255; presc = 4'd3;
    do_load(8'd0);
    repeat (4) step("presc");
    check("presc_first", 32'(cnt), 32'd1);
    repeat (2) step("presc");
    en = 1'b0;
    repeat (2) step("presc_gap");
    en = 1'b1;
    step("presc");
    check("presc_gap_hold", 32'(cnt), 32'd1);
    step("presc");
    check("presc_gap_tick", 32'(cnt), 32'd2);

    // Load above max_val
    presc = '0; max_val = 8'd9; sat = 1'b0;
    do_load(8'd12);
    step("above");
    check("above_wrap_cnt", 32'(cnt), 32'd0);
    check("above_wrap_tc",  32'(tc),  32'd1);
    sat = 1'b1;
    do_load(8'd12);
    step("above");
    check("above_sat_cnt", 32'(cnt), 32'd9);

    // ovf clear contention
    sat = 1'b0; en = 1'b0; clr_ovf = 1'b1;
    step("clr");
    check("clr_ovf", 32'(ovf), 32'd0);
    clr_ovf = 1'b0;
    do_load(8'd9);
    en = 1'b1; clr_ovf = 1'b1;
    step("clr_vs_evt");
    check("clr_vs_evt_ovf", 32'(ovf), 32'd1);
    clr_ovf = 1'b0;

    // Asynchronous reset mid-count
    max_val = 8'd200;
    repeat (3) step("pre_rst");
    async_reset("async_rst");
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_ovf", 32'(ovf), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load    = ($urandom_range(0, 15) == 0);
      din     = 8'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom);
      sat     = 1'($urandom);
      max_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      presc   = 4'($urandom_range(0, 3));
      clr_ovf = ($urandom_range(0, 7) == 0);
      step("rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
